// File: rtl/matrix_entry_sequencer.sv
// Operator matrix entry: debounced "enter" key captures switch values row-major into a
// buffer that the Nios CPU controls and reads back over an Avalon-MM slave.
module matrix_entry_sequencer #(
    parameter int DATA_W          = 8,
    parameter int MAX_DIM         = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_port,
    input  logic              key_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic              busy
);

    localparam int DEPTH  = MAX_DIM * MAX_DIM;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = $clog2(DEPTH + 1);
    localparam int DIM_W  = $clog2(MAX_DIM);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CTRL_W = 2 + 2 * DIM_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              key_meta_q, key_meta_d;
    logic              key_sync_q, key_sync_d;
    logic              key_last_q, key_last_d;
    logic              deb_q, deb_d;
    logic              deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
    logic [DATA_W-1:0] in_meta_q, in_meta_d;
    logic [DATA_W-1:0] in_sync_q, in_sync_d;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              irq_en_q, irq_en_d;
    logic [31:0]       readdata_q, readdata_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              press;
    logic              wr;
    logic              rd;
    logic [PTR_W-1:0]  last_idx;
    logic [31:0]       status_word;
    logic              unused_wdata;

    assign unused_wdata = ^writedata[31:CTRL_W];

    // Key and switch synchronizers, then a stability counter that saturates once the level is accepted
    always_comb begin
        key_meta_d = key_n;
        key_sync_d = key_meta_q;
        key_last_d = key_sync_q;
        in_meta_d  = in_port;
        in_sync_d  = in_meta_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        db_cnt_d   = db_cnt_q;
        if (key_sync_q != key_last_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = key_sync_q;
        end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
        end
    end

    assign press    = deb_prev_q & ~deb_q;
    assign wr       = chipselect & write;
    assign rd       = chipselect & read;
    assign last_idx = (PTR_W'(rows_q) + PTR_W'(1)) * (PTR_W'(cols_q) + PTR_W'(1)) - PTR_W'(1);

    // Any CTRL write takes priority over a simultaneous press, which is then dropped
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        index_d   = index_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        irq_en_d  = irq_en_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q[IDX_W-1:0];
        mem_wdata = in_sync_q;

        if (wr && address == 3'd0) begin
            rows_d = writedata[2 +: DIM_W];
            cols_d = writedata[2 + DIM_W +: DIM_W];
            if (writedata[1]) begin
                state_d = ST_IDLE;
                ptr_d   = '0;
                done_d  = 1'b0;
                ovf_d   = 1'b0;
            end else if (writedata[0]) begin
                state_d = ST_ARMED;
                ptr_d   = '0;
                done_d  = 1'b0;
            end
        end else if (press) begin
            if (state_q == ST_ARMED) begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + PTR_W'(1);
                if (ptr_q == last_idx) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (wr && address == 3'd1) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end
        if (wr && address == 3'd3) begin
            index_d = writedata[IDX_W-1:0];
        end
        if (wr && address == 3'd4) begin
            irq_en_d = writedata[0];
        end
    end

    always_comb begin
        status_word            = '0;
        status_word[0]         = (state_q == ST_ARMED);
        status_word[1]         = done_q;
        status_word[2]         = ovf_q;
        status_word[4 +: PTR_W] = ptr_q;
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd) begin
            case (address)
                3'd1:    readdata_d = status_word;
                3'd2:    readdata_d = 32'(mem_q[index_q]);
                3'd3:    readdata_d = 32'(index_q);
                3'd4:    readdata_d = 32'(irq_en_q);
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            key_last_q <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            db_cnt_q   <= '0;
            in_meta_q  <= '0;
            in_sync_q  <= '0;
            ptr_q      <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            index_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            key_last_q <= key_last_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            db_cnt_q   <= db_cnt_d;
            in_meta_q  <= in_meta_d;
            in_sync_q  <= in_sync_d;
            ptr_q      <= ptr_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            index_q    <= index_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            readdata_q <= readdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign readdata = readdata_q;
    assign irq      = done_q & irq_en_q;
    assign busy     = (state_q == ST_ARMED);

endmodule

// File: tb/tb_matrix_entry_sequencer.sv
// Directed bench for matrix_entry_sequencer: Avalon reads are scored against a queue of
// expected values pushed when each read is issued.
module tb_matrix_entry_sequencer;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_port;
    logic        key_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        busy;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    logic [31:0] exp_q [$];

    matrix_entry_sequencer #(
        .DATA_W         (8),
        .MAX_DIM        (4),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .key_n     (key_n),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic av_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic av_read(input string tag, input logic [2:0] a, input logic [31:0] e);
        @(negedge clk);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        check(tag, readdata, exp_q.pop_front());
    endtask

    task automatic key_press(input logic [7:0] v);
        @(negedge clk);
        in_port = v;
        repeat (4) @(negedge clk);
        key_n = 1'b0;
        repeat (25) @(negedge clk);
        key_n = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    initial begin
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        reset_n    = 1'b0;
        in_port    = '0;
        key_n      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        av_read("rst_status", 3'd1, 32'h0);

        // 2x2 entry
        av_write(3'd0, 32'h15);
        check("2x2_busy_armed", 32'(busy), 32'h1);
        for (int i = 0; i < 4; i++) key_press(vals[i]);
        av_read("2x2_status", 3'd1, 32'h42);
        check("2x2_busy_done", 32'(busy), 32'h0);
        check("2x2_irq_masked", 32'(irq), 32'h0);
        for (int i = 0; i < 4; i++) begin
            av_write(3'd3, 32'(i));
            av_read("2x2_index", 3'd3, 32'(i));
            av_read("2x2_data", 3'd2, 32'(vals[i]));
        end
        av_read("unmapped_read", 3'd6, 32'h0);
        av_read("data_again", 3'd2, 32'h44);
        repeat (3) @(negedge clk);
        check("readdata_hold", readdata, 32'h44);

        // bouncing key
        av_write(3'd0, 32'h15);
        av_read("bounce_restart", 3'd1, 32'h01);
        @(negedge clk);
        in_port = 8'h5A;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 3 == 0) key_n = ~key_n;
        end
        key_n = 1'b0;
        repeat (25) @(negedge clk);
        key_n = 1'b1;
        repeat (25) @(negedge clk);
        av_read("bounce_status", 3'd1, 32'h11);
        av_write(3'd3, 32'h0);
        av_read("bounce_data", 3'd2, 32'h5A);

        // interrupt on 1x1 entry
        av_write(3'd4, 32'h1);
        av_read("irqen_read", 3'd4, 32'h1);
        av_write(3'd0, 32'h01);
        check("irq_before", 32'(irq), 32'h0);
        key_press(8'hA5);
        check("irq_after_capture", 32'(irq), 32'h1);
        av_read("1x1_status", 3'd1, 32'h12);
        av_write(3'd3, 32'h0);
        av_read("1x1_data", 3'd2, 32'hA5);
        av_write(3'd1, 32'h0);
        check("irq_cleared", 32'(irq), 32'h0);
        av_read("status_cleared", 3'd1, 32'h10);

        // overflow and clear priority
        av_write(3'd0, 32'h02);
        av_read("idle_status", 3'd1, 32'h0);
        key_press(8'h77);
        av_read("overflow_status", 3'd1, 32'h04);
        av_read("overflow_buf_kept", 3'd2, 32'hA5);
        av_write(3'd0, 32'h03);
        av_read("clear_wins", 3'd1, 32'h0);
        check("clear_wins_busy", 32'(busy), 32'h0);

        // CTRL write held across a press in ARMED
        av_write(3'd0, 32'h3D);
        key_press(8'h01);
        av_read("4x4_first", 3'd1, 32'h11);
        @(negedge clk);
        in_port    = 8'h66;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 3'd0;
        writedata  = 32'h3C;
        repeat (4) @(negedge clk);
        key_n = 1'b0;
        repeat (25) @(negedge clk);
        key_n = 1'b1;
        repeat (3) @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        repeat (22) @(negedge clk);
        av_read("coincident_dropped", 3'd1, 32'h11);

        // restart mid-entry
        key_press(8'h02);
        av_read("4x4_second", 3'd1, 32'h21);
        av_write(3'd0, 32'h3D);
        av_read("restart_status", 3'd1, 32'h01);
        check("restart_busy", 32'(busy), 32'h1);
        key_press(8'h99);
        av_read("restart_ptr", 3'd1, 32'h11);
        av_write(3'd3, 32'h0);
        av_read("restart_data0", 3'd2, 32'h99);
        av_write(3'd3, 32'h1);
        av_read("restart_stale1", 3'd2, 32'h02);

        // asynchronous reset mid-entry
        key_press(8'h03);
        key_press(8'h04);
        av_read("pre_reset_status", 3'd1, 32'h31);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_readdata", readdata, 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        av_read("post_reset_status", 3'd1, 32'h0);
        av_read("post_reset_irqen", 3'd4, 32'h0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
